// File: rtl/snd_pkg.sv
// Shared types and constants for the sound-request scheduler.
// Holds the sound table, source IDs and the scheduler FSM state type.
package snd_pkg;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned N_SRC  = 4;
  localparam int unsigned ID_W   = 2;

  localparam logic [ID_W-1:0] TICTAC    = 2'd0;
  localparam logic [ID_W-1:0] BONUS     = 2'd1;
  localparam logic [ID_W-1:0] EXPLOSION = 2'd2;
  localparam logic [ID_W-1:0] DEATH     = 2'd3;

  // Inclusive sample ranges, indexed by source ID.
  localparam logic [ADDR_W-1:0] SND_START [N_SRC] = '{14'd0, 14'd11965, 14'd3847, 14'd13965};
  localparam logic [ADDR_W-1:0] SND_END   [N_SRC] = '{14'd3846, 14'd13964, 14'd11964, 14'd16383};

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StPlay,
    StAbort
  } snd_state_e;

endpackage

// File: rtl/prio_enc.sv
// Highest-set-bit encoder: returns the index of the most significant set bit
// and a flag telling whether any bit is set.
module prio_enc #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    vec_i,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (vec_i[i]) begin
        idx_o = IdxW'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snd_scheduler.sv
// Sound-request scheduler: latches request pulses, issues the highest-priority
// sound to the player and preempts lower-priority playback.
module snd_scheduler
  import snd_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [N_SRC-1:0]  req_i,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic [ADDR_W-1:0] cmd_start_o,
  output logic [ADDR_W-1:0] cmd_end_o,
  output logic [ID_W-1:0]   cmd_id_o,
  output logic              abort_o,
  input  logic              player_busy_i,
  input  logic              player_done_i,
  output logic [N_SRC-1:0]  pending_o,
  output logic [7:0]        drop_cnt_o
);

  snd_state_e        state_q, state_d;
  logic [N_SRC-1:0]  pending_q, pending_d;
  logic [7:0]        drop_q, drop_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [ADDR_W-1:0] cmd_start_q, cmd_start_d;
  logic [ADDR_W-1:0] cmd_end_q, cmd_end_d;
  logic [ID_W-1:0]   cmd_id_q, cmd_id_d;
  logic              abort_q, abort_d;

  logic [N_SRC-1:0]  clr;
  logic [N_SRC-1:0]  lost;
  logic [ID_W-1:0]   sel_idx;
  logic              sel_any;
  logic [2:0]        lost_num;
  logic [8:0]        drop_sum;

  // One encoder serves both idle selection and the preemption compare.
  prio_enc #(
    .N    (N_SRC),
    .IdxW (ID_W)
  ) u_prio_enc (
    .vec_i (pending_q),
    .idx_o (sel_idx),
    .any_o (sel_any)
  );

  always_comb begin
    state_d     = state_q;
    cur_id_d    = cur_id_q;
    cmd_valid_d = cmd_valid_q;
    cmd_start_d = cmd_start_q;
    cmd_end_d   = cmd_end_q;
    cmd_id_d    = cmd_id_q;
    abort_d     = 1'b0;
    clr         = '0;
    unique case (state_q)
      StIdle: begin
        if (sel_any) begin
          clr[sel_idx] = 1'b1;
          cmd_valid_d  = 1'b1;
          cmd_start_d  = SND_START[sel_idx];
          cmd_end_d    = SND_END[sel_idx];
          cmd_id_d     = sel_idx;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        if (cmd_ready_i) begin
          cur_id_d    = cmd_id_q;
          cmd_valid_d = 1'b0;
          state_d     = StPlay;
        end
      end
      StPlay: begin
        if (player_done_i) begin
          state_d = StIdle;
        end else if (sel_any && (sel_idx > cur_id_q)) begin
          abort_d = 1'b1;
          state_d = StAbort;
        end
      end
      StAbort: begin
        if (!player_busy_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A request hitting a bit that is set and not being cleared is lost.
  always_comb begin
    lost      = req_i & pending_q & ~clr;
    pending_d = (pending_q & ~clr) | req_i;
    lost_num  = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      lost_num = lost_num + {2'b00, lost[i]};
    end
    drop_sum = {1'b0, drop_q} + {6'd0, lost_num};
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      drop_q      <= '0;
      cur_id_q    <= '0;
      cmd_valid_q <= 1'b0;
      cmd_start_q <= '0;
      cmd_end_q   <= '0;
      cmd_id_q    <= '0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      drop_q      <= drop_d;
      cur_id_q    <= cur_id_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_start_q <= cmd_start_d;
      cmd_end_q   <= cmd_end_d;
      cmd_id_q    <= cmd_id_d;
      abort_q     <= abort_d;
    end
  end

  assign cmd_valid_o = cmd_valid_q;
  assign cmd_start_o = cmd_start_q;
  assign cmd_end_o   = cmd_end_q;
  assign cmd_id_o    = cmd_id_q;
  assign abort_o     = abort_q;
  assign pending_o   = pending_q;
  assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_snd_scheduler.sv
// Self-checking bench for snd_scheduler: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_snd_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [13:0] cmd_start;
  logic [13:0] cmd_end;
  logic [1:0]  cmd_id;
  logic        abort;
  logic        player_busy;
  logic        player_done;
  logic [3:0]  pending;
  logic [7:0]  drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  snd_scheduler dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_i         (req),
    .cmd_valid_o   (cmd_valid),
    .cmd_ready_i   (cmd_ready),
    .cmd_start_o   (cmd_start),
    .cmd_end_o     (cmd_end),
    .cmd_id_o      (cmd_id),
    .abort_o       (abort),
    .player_busy_i (player_busy),
    .player_done_i (player_done),
    .pending_o     (pending),
    .drop_cnt_o    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: what is waiting, what is offered, what is playing.
  int tab_start [4] = '{0, 11965, 3847, 13965};
  int tab_end   [4] = '{3846, 13964, 11964, 16383};

  // phase: 0 nothing offered, 1 offering, 2 sound playing, 3 waiting for player stop
  int       m_phase;
  bit       m_valid, m_abort;
  int       m_start, m_end, m_id, m_cur, m_drop, m_hi;
  bit [3:0] m_pend, m_clr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_valid = 0; m_abort = 0; m_start = 0; m_end = 0;
      m_id = 0; m_cur = 0; m_drop = 0; m_pend = 0;
    end else begin
      m_hi = -1;
      for (int i = 0; i < 4; i++) if (m_pend[i]) m_hi = i;
      m_clr = 0;
      m_abort = 0;
      case (m_phase)
        0: if (m_hi >= 0) begin
          m_clr[m_hi] = 1'b1;
          m_valid = 1; m_start = tab_start[m_hi]; m_end = tab_end[m_hi]; m_id = m_hi;
          m_phase = 1;
        end
        1: if (cmd_ready) begin m_cur = m_id; m_valid = 0; m_phase = 2; end
        2: if (player_done) m_phase = 0;
           else if (m_hi > m_cur) begin m_abort = 1; m_phase = 3; end
        3: if (!player_busy) m_phase = 0;
        default: m_phase = 0;
      endcase
      for (int i = 0; i < 4; i++)
        if (req[i] && m_pend[i] && !m_clr[i] && m_drop < 255) m_drop++;
      m_pend = (m_pend & ~m_clr) | req;
    end
  end

  task automatic cmp_cycle();
    logic [46:0] act, exp;
    act = {cmd_valid, cmd_start, cmd_end, cmd_id, abort, pending, drop_cnt};
    exp = {m_valid, 14'(m_start), 14'(m_end), 2'(m_id), m_abort, m_pend, 8'(m_drop)};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL cycle t=%0t got v=%0b s=%0d e=%0d id=%0d ab=%0b p=%b d=%0d want v=%0b s=%0d e=%0d id=%0d ab=%0b p=%b d=%0d",
               $time, cmd_valid, cmd_start, cmd_end, cmd_id, abort, pending, drop_cnt,
               m_valid, m_start, m_end, m_id, m_abort, m_pend, m_drop);
    end
  endtask

  // Compare on the falling edge, then move to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    cmp_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; cmd_ready = 1'b0; player_busy = 1'b0; player_done = 1'b0;
    tick(); tick();
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_start", int'(cmd_start), 0);
    chk("rst_id", int'(cmd_id), 0);
    chk("rst_pend", int'(pending), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    rst_n = 1'b1;
    tick();

    // Single tictac request, ready tied high.
    cmd_ready = 1'b1;
    req = 4'b0001; tick(); req = '0;
    chk("single_pend", int'(pending), 1);
    chk("single_valid_early", int'(cmd_valid), 0);
    tick();
    chk("single_valid", int'(cmd_valid), 1);
    chk("single_start", int'(cmd_start), 0);
    chk("single_end", int'(cmd_end), 3846);
    chk("single_id", int'(cmd_id), 0);
    tick();
    chk("single_accept", int'(cmd_valid), 0);
    player_busy = 1'b1;
    repeat (3) tick();
    player_done = 1'b1; tick(); player_done = 1'b0; player_busy = 1'b0;
    tick();
    chk("single_idle", int'(cmd_valid), 0);

    // Simultaneous explosion and tictac.
    req = 4'b0101; tick(); req = '0;
    chk("dual_pend", int'(pending), 5);
    tick();
    chk("dual_first_start", int'(cmd_start), 3847);
    chk("dual_first_end", int'(cmd_end), 11964);
    chk("dual_first_id", int'(cmd_id), 2);
    chk("dual_pend_left", int'(pending), 1);
    tick();
    player_busy = 1'b1; player_done = 1'b1; tick(); player_done = 1'b0;
    tick();
    chk("dual_second_valid", int'(cmd_valid), 1);
    chk("dual_second_start", int'(cmd_start), 0);
    chk("dual_pend_empty", int'(pending), 0);
    tick();

    // Explosion preempts tictac; wait for player to stop.
    req = 4'b0100; tick(); req = '0;
    chk("pre_abort_before", int'(abort), 0);
    tick();
    chk("pre_abort", int'(abort), 1);
    tick();
    chk("pre_abort_once", int'(abort), 0);
    repeat (5) tick();
    chk("pre_wait_valid", int'(cmd_valid), 0);
    player_busy = 1'b0; tick();
    chk("pre_idle_valid", int'(cmd_valid), 0);
    tick();
    chk("pre_issue_valid", int'(cmd_valid), 1);
    chk("pre_issue_start", int'(cmd_start), 3847);
    tick();

    // Lower priority waits for completion.
    player_busy = 1'b1;
    req = 4'b0001; tick(); req = '0;
    repeat (3) tick();
    chk("nopre_abort", int'(abort), 0);
    chk("nopre_pend", int'(pending), 1);
    player_done = 1'b1; tick(); player_done = 1'b0;
    tick();
    chk("nopre_issue_id", int'(cmd_id), 0);
    chk("nopre_issue_valid", int'(cmd_valid), 1);
    tick();

    // Done and a higher request seen in the same cycle: done wins.
    req = 4'b1000; tick(); req = '0; player_done = 1'b1;
    tick(); player_done = 1'b0;
    chk("done_wins_abort", int'(abort), 0);
    tick();
    chk("done_wins_id", int'(cmd_id), 3);
    chk("done_wins_start", int'(cmd_start), 13965);
    chk("done_wins_end", int'(cmd_end), 16383);
    tick();
    player_done = 1'b1; tick(); player_done = 1'b0; player_busy = 1'b0;
    tick();

    // Drops while the command is stuck waiting for ready.
    cmd_ready = 1'b0;
    req = 4'b0001; tick(); req = '0;
    tick();
    req = 4'b0001; repeat (3) tick(); req = '0;
    chk("drop_cnt2", int'(drop_cnt), 2);
    chk("drop_pend", int'(pending), 1);
    repeat (10) tick();
    chk("hold_valid", int'(cmd_valid), 1);
    chk("hold_start", int'(cmd_start), 0);
    chk("hold_end", int'(cmd_end), 3846);

    // Asynchronous reset while offering a command.
    rst_n = 1'b0; #1;
    chk("arst_valid", int'(cmd_valid), 0);
    chk("arst_pend", int'(pending), 0);
    chk("arst_drop", int'(drop_cnt), 0);
    tick(); rst_n = 1'b1; tick();

    // Saturation of the drop counter.
    req = 4'b0001; repeat (305) tick(); req = '0;
    chk("drop_sat", int'(drop_cnt), 255);
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();

    // Random traffic checked cycle by cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 4; b++) req[b] = ($urandom_range(99) < 6);
      cmd_ready   = ($urandom_range(99) < 50);
      player_busy = ($urandom_range(99) < 60);
      player_done = ($urandom_range(99) < 8);
      rst_n       = ($urandom_range(999) >= 2);
      tick();
    end
    rst_n = 1'b1; req = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
